// File: rtl/quad_dec.sv
// ---------------------------------------------------------------------------
// quad_dec
//
// Quadrature rotary-encoder front end for the LED dimmer. The two encoder
// contacts are synchronised and debounced. The accepted {a,b} state is then
// decoded as a Gray-code position. One inc/dec pulse is produced per
// mechanical detent, and illegal two-bit jumps are flagged on err.
//
// Parameters
//   DEB_CYCLES       : clocks a new contact level must persist before it is
//                      accepted (>= 1)
//   STEPS_PER_DETENT : quadrature steps per output pulse (1, 2 or 4)
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active low
//   enc_a  : contact A, asynchronous, idle high
//   enc_b  : contact B, asynchronous, idle high
//   inc    : one-cycle pulse per clockwise detent
//   dec    : one-cycle pulse per counter-clockwise detent
//   err    : one-cycle pulse when both contacts are accepted in one cycle
// ---------------------------------------------------------------------------
module quad_dec #(
    parameter int DEB_CYCLES       = 50000,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enc_a,
    input  logic enc_b,
    output logic inc,
    output logic dec,
    output logic err
);

    localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic signed [3:0] ACC_TOP  = 4'(STEPS_PER_DETENT);

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_CW,
        STEP_CCW,
        STEP_BAD
    } step_t;

    // Classify one transition of the accepted {a,b} state. The clockwise
    // order is 11 -> 10 -> 00 -> 01 -> 11. Any single-bit change that is not
    // clockwise is therefore counter-clockwise.
    function automatic step_t gray_step(input logic [1:0] from_ab,
                                        input logic [1:0] to_ab);
        step_t result;
        result = STEP_CCW;
        if (from_ab == to_ab) begin
            result = STEP_NONE;
        end else if ((from_ab ^ to_ab) == 2'b11) begin
            result = STEP_BAD;
        end else begin
            case ({from_ab, to_ab})
                4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: result = STEP_CW;
                default:                                result = STEP_CCW;
            endcase
        end
        return result;
    endfunction

    // Bit 1 carries contact A and bit 0 carries contact B.
    logic [1:0]       sync_p0;
    logic [1:0]       sync_p1;
    logic [1:0]       stable;
    logic [CNT_W-1:0] deb_cnt [2];
    logic [1:0]       prev;
    logic signed [3:0] acc;

    step_t             step;
    logic signed [3:0] acc_nxt;
    logic              inc_nxt;
    logic              dec_nxt;
    logic              err_nxt;

    // ---- stage 0/1: two-flop synchroniser; only sync_p1 is used downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 2'b11;
            sync_p1 <= 2'b11;
        end else begin
            sync_p0 <= {enc_a, enc_b};
            sync_p1 <= sync_p0;
        end
    end

    // ---- stage 2: per-channel debounce. A differing level must be seen for
    // DEB_CYCLES consecutive clocks. Any return to the stable level restarts
    // the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    stable[i]  <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // ---- stage 3: decode and detent accumulation
    always_comb begin
        step    = gray_step(prev, stable);
        acc_nxt = acc;
        inc_nxt = 1'b0;
        dec_nxt = 1'b0;
        err_nxt = 1'b0;
        case (step)
            STEP_CW: begin
                if (acc + 4'sd1 == ACC_TOP) begin
                    acc_nxt = '0;
                    inc_nxt = 1'b1;
                end else begin
                    acc_nxt = acc + 4'sd1;
                end
            end
            STEP_CCW: begin
                if (acc - 4'sd1 == -ACC_TOP) begin
                    acc_nxt = '0;
                    dec_nxt = 1'b1;
                end else begin
                    acc_nxt = acc - 4'sd1;
                end
            end
            STEP_BAD: begin
                acc_nxt = '0;
                err_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 2'b11;
            acc  <= '0;
            inc  <= 1'b0;
            dec  <= 1'b0;
            err  <= 1'b0;
        end else begin
            prev <= stable;
            acc  <= acc_nxt;
            inc  <= inc_nxt;
            dec  <= dec_nxt;
            err  <= err_nxt;
        end
    end

endmodule
